mouse_axis_emu: RTL

//  Converts PS/2 mouse packets into emulated analog joystick axes for the 5200/800 controller path.
//  - Accumulates per-packet X/Y deltas into saturating signed axis registers, with sensitivity and step limiting.
//  - Offers a hold mode and a spring (auto-recentre) mode.
//  - Yields to a real analog stick or to CPU halt.
//  - Sits between hps_io (ps2_mouse, joystick_analog) and the core's JOY1X/JOY1Y/JOY1 fire inputs.

---
 rtl/mouse_axis_emu.sv | 115 +++++++++++
 1 files changed

// File: rtl/mouse_axis_emu.sv
// PS/2 mouse packets to emulated analog joystick axes: saturating signed accumulators with
// per-packet step limiting, hold / spring (auto-recentre) modes and yield to a real stick or CPU halt.
module mouse_axis_emu #(
   parameter int AXW           = 8,
   parameter int SHIFT         = 1,
   parameter int STEP_MAX      = 10,
   parameter int RECENTER_DIV  = 50000,
   parameter int RECENTER_STEP = 1
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [24:0]           MOUSE,
   input  logic [2*AXW-1:0]      JOYA,
   input  logic                  HALT,
   input  logic                  MODE,
   input  logic                  INVERT_Y,
   output logic signed [AXW-1:0] AX,
   output logic signed [AXW-1:0] AY,
   output logic [1:0]            BTN,
   output logic                  ACTIVE
);
   localparam int DW = (AXW + 2 > 11) ? AXW + 2 : 11;
   localparam int CW = $clog2(RECENTER_DIV);
   localparam logic [CW-1:0]        CNT_LAST = CW'(RECENTER_DIV - 1);
   localparam logic signed [DW-1:0] STEP_HI  = DW'(STEP_MAX);
   localparam logic signed [DW-1:0] STEP_LO  = -STEP_HI;
   localparam logic signed [DW-1:0] AX_HI    = DW'((2 ** (AXW - 1)) - 1);
   localparam logic signed [DW-1:0] AX_LO    = ~AX_HI;
   localparam logic signed [DW-1:0] RC_STEP  = DW'(RECENTER_STEP);

   function automatic logic signed [DW-1:0] axis_delta(input logic sign, input logic [7:0] data,
                                                       input logic neg);
      logic signed [DW-1:0] d;
      d = {{(DW-8){sign}}, data};
      d = d >>> SHIFT;
      if (neg) d = -d;
      if (d > STEP_HI) d = STEP_HI;
      else if (d < STEP_LO) d = STEP_LO;
      return d;
   endfunction

   function automatic logic signed [AXW-1:0] sat_axis(input logic signed [DW-1:0] s);
      logic signed [DW-1:0] r;
      r = s;
      if (s > AX_HI) r = AX_HI;
      else if (s < AX_LO) r = AX_LO;
      return r[AXW-1:0];
   endfunction

   // A recentre step never crosses zero: anything within one step lands exactly on 0.
   function automatic logic signed [AXW-1:0] toward_zero(input logic signed [AXW-1:0] a);
      logic signed [DW-1:0] v;
      v = DW'(a);
      if (v > RC_STEP) v = v - RC_STEP;
      else if (v < -RC_STEP) v = v + RC_STEP;
      else v = '0;
      return v[AXW-1:0];
   endfunction

   logic                  stb_p1;
   logic                  vld_p1;
   logic [1:0]            btn_p1;
   logic [CW-1:0]         cnt_p1;
   logic signed [AXW-1:0] acc_x_p1, acc_y_p1;

   logic                  evt, takeover;
   logic signed [DW-1:0]  dx, dy;
   logic signed [AXW-1:0] nx, ny;
   logic                  unused_mouse;

   assign unused_mouse = ^{MOUSE[7:6], MOUSE[3:2]};

   // Stage p0: packet detect and delta path
   always_comb begin
      evt      = MOUSE[24] ^ stb_p1;
      takeover = (JOYA != '0) || HALT;
      dx       = axis_delta(MOUSE[4], MOUSE[15:8], 1'b0);
      dy       = axis_delta(MOUSE[5], MOUSE[23:16], INVERT_Y);
      nx       = sat_axis(DW'(acc_x_p1) + dx);
      ny       = sat_axis(DW'(acc_y_p1) + dy);
   end

   // Stage p1: accumulators and ownership
   always_ff @(posedge CLK) begin
      stb_p1 <= MOUSE[24];
      if (!RESET_N || takeover) begin
         acc_x_p1 <= '0;
         acc_y_p1 <= '0;
         btn_p1   <= '0;
         vld_p1   <= 1'b0;
         cnt_p1   <= '0;
      end else if (evt) begin
         acc_x_p1 <= nx;
         acc_y_p1 <= ny;
         btn_p1   <= MOUSE[1:0];
         vld_p1   <= 1'b1;
         cnt_p1   <= '0;
      end else if (MODE && vld_p1) begin
         if (cnt_p1 == CNT_LAST) begin
            cnt_p1   <= '0;
            acc_x_p1 <= toward_zero(acc_x_p1);
            acc_y_p1 <= toward_zero(acc_y_p1);
         end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
         end
      end else begin
         cnt_p1 <= '0;
      end
   end

   assign AX     = vld_p1 ? acc_x_p1 : JOYA[AXW-1:0];
   assign AY     = vld_p1 ? acc_y_p1 : JOYA[2*AXW-1:AXW];
   assign BTN    = vld_p1 ? btn_p1 : 2'b00;
   assign ACTIVE = vld_p1;
endmodule
